// File: rtl/mips_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : mips_ifetch
// Purpose  : MIPS instruction-fetch stage: owns the PC and imem and feeds the
//            IF/ID register; handles stall, redirect and sticky fetch faults.
// Revision : 1.0 - initial release
// ============================================================================
module mips_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          IM_AW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [1:0]  c_st_boot  = 2'd0;
  localparam logic [1:0]  c_st_run   = 2'd1;
  localparam logic [1:0]  c_st_fault = 2'd2;
  localparam logic [31:0] c_span     = 32'(IMEM_DEPTH) << 2;

  logic [31:0]      imem [0:IMEM_DEPTH-1];
  logic [1:0]       r_state;
  logic [31:0]      w_off;
  logic             w_in_range;
  logic [IM_AW-1:0] w_idx;
  logic             w_redir_misaligned;

  // Unsigned offset: addresses below RESET_PC wrap to huge values and fail the
  // single compare, so one test covers both ends of the window.
  assign w_off              = PC - RESET_PC;
  assign w_in_range         = (w_off < c_span);
  assign w_idx              = w_off[IM_AW+1:2];
  assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_boot;
      PC          <= RESET_PC;
      instr       <= 32'd0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (r_state)
        c_st_boot, c_st_run: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            PC          <= redirect_pc;
            if (w_redir_misaligned) begin
              r_state <= c_st_fault;
              fault   <= 1'b1;
            end else begin
              r_state <= c_st_run;
            end
          end else if (r_state == c_st_boot) begin
            r_state <= c_st_run;
          end else if (!id_stall) begin
            if (w_in_range) begin
              instr       <= imem[w_idx];
              instr_pc    <= PC;
              instr_valid <= 1'b1;
              PC          <= PC + 32'd4;
              fetch_count <= fetch_count + 32'd1;
            end else begin
              r_state     <= c_st_fault;
              fault       <= 1'b1;
              instr_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= c_st_fault;
          fault       <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_ifetch
// Purpose  : Scoreboard bench for mips_ifetch: directed plan plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_ifetch;

  localparam logic [31:0] c_base  = 32'h0000_3000;
  localparam int          c_depth = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] PC, instr, instr_pc, fetch_count;
  logic        instr_valid, fault;

  mips_ifetch #(.RESET_PC(c_base), .IMEM_DEPTH(c_depth), .IM_AW(10)) dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .PC(PC), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ins, ipc, cnt;
    logic        vld, flt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mem [0:c_depth-1];

  // Reference model: fetch state described as "booting / faulted" flags.
  logic [31:0] m_pc, m_ins, m_ipc, m_cnt;
  logic        m_vld, m_flt;
  bit          m_booting;

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = longint'(a);
    lo = longint'(c_base);
    hi = lo + 4 * c_depth;
    return (la >= lo) && (la < hi);
  endfunction

  task automatic model_edge(input bit r, input bit st, input bit rv, input logic [31:0] rpc);
    if (r) begin
      m_pc = c_base; m_ins = 0; m_ipc = c_base; m_vld = 0; m_flt = 0; m_cnt = 0;
      m_booting = 1;
    end else if (m_flt) begin
      m_vld = 0;
    end else if (rv) begin
      m_vld = 0;
      m_pc = rpc;
      m_booting = 0;
      if (rpc % 4 != 0) m_flt = 1;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (!st) begin
      if (in_window(m_pc)) begin
        m_ins = mem[(m_pc - c_base) / 4];
        m_ipc = m_pc;
        m_vld = 1;
        m_pc  = m_pc + 4;
        m_cnt = m_cnt + 1;
      end else begin
        m_flt = 1;
        m_vld = 0;
      end
    end
  endtask

  // Drive one cycle at the falling edge, predict, queue, wait for the next fall.
  task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rpc);
    exp_t e;
    rst = r; id_stall = st; redirect_valid = rv; redirect_pc = rpc;
    model_edge(r, st, rv, rpc);
    e.pc = m_pc; e.ins = m_ins; e.ipc = m_ipc; e.cnt = m_cnt; e.vld = m_vld; e.flt = m_flt;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents a new IF/ID word; compare against queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (PC !== e.pc || instr_valid !== e.vld || fault !== e.flt || fetch_count !== e.cnt ||
            (e.vld && (instr !== e.ins || instr_pc !== e.ipc))) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: got pc=%h v=%b f=%b cnt=%h ipc=%h ins=%h expected pc=%h v=%b f=%b cnt=%h ipc=%h ins=%h",
                   $time, PC, instr_valid, fault, fetch_count, instr_pc, instr,
                   e.pc, e.vld, e.flt, e.cnt, e.ipc, e.ins);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    int          r;
    mem[0] = 32'h20080001; mem[1] = 32'h20090002; mem[2] = 32'h01095020; mem[3] = 32'h00000000;
    for (int i = 4; i < c_depth; i++) mem[i] = $urandom;
    for (int i = 0; i < c_depth; i++) dut.imem[i] = mem[i];

    // Reset and sequential fetch
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("reset_pc", PC, 32'h3000);
    chk("reset_valid", {31'd0, instr_valid}, 0);
    step(0, 0, 0, 0);
    chk("boot_no_fetch", {31'd0, instr_valid}, 0);
    step(0, 0, 0, 0);
    chk("first_ipc", instr_pc, 32'h3000);
    chk("first_instr", instr, 32'h20080001);
    step(0, 0, 0, 0);
    chk("second_instr", instr, 32'h20090002);
    chk("count_2", fetch_count, 2);

    // Stall while instr_pc = 0x3004
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("stall_pc", PC, 32'h3008);
    chk("stall_ipc", instr_pc, 32'h3004);
    step(0, 0, 0, 0);
    chk("after_stall_ipc", instr_pc, 32'h3008);

    // Redirect under stall
    step(0, 1, 1, 32'h3010);
    chk("redir_flush", {31'd0, instr_valid}, 0);
    chk("redir_pc", PC, 32'h3010);
    step(0, 0, 0, 0);
    chk("redir_instr", instr, mem[4]);

    // Misaligned redirect, then ignored redirects
    step(0, 0, 1, 32'h3002);
    chk("misalign_fault", {31'd0, fault}, 1);
    for (int i = 0; i < 10; i++) step(0, i[0], 1, 32'h3000 + 4 * i);
    chk("fault_sticky", {31'd0, fault}, 1);
    chk("fault_pc_frozen", PC, 32'h3002);

    // End of memory
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h3FFC);
    step(0, 0, 0, 0);
    chk("last_word", instr, mem[1023]);
    step(0, 0, 0, 0);
    chk("end_fault", {31'd0, fault}, 1);
    chk("end_pc", PC, 32'h4000);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h2FFC);
    step(0, 0, 0, 0);
    chk("below_fault", {31'd0, fault}, 1);

    // Reset from fault
    step(1, 0, 0, 0);
    chk("rst_clears_fault", {31'd0, fault}, 0);
    chk("rst_count", fetch_count, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("resume_ipc", instr_pc, 32'h3000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) t = c_base + 4 * $urandom_range(0, 1023);
      else if (r < 9) t = 32'h3FF0 + 4 * $urandom_range(0, 3);
      else if (r < 10) t = c_base + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
      else if (r < 11) t = (r[0]) ? 32'h2FFC : 32'h5000;
      else t = c_base + 4 * $urandom_range(0, 1023);
      if ((m_flt && $urandom_range(0, 4) == 0) || $urandom_range(0, 199) == 0)
        step(1, 0, 0, 0);
      else
        step(0, $urandom_range(0, 9) < 3, r < 11, t);
    end
    @(negedge clk);

    if (sb_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
